servo_bank_scheduler: RTL and testbench

Controller that owns the commanded positions and enables for a bank of `servo_pwm_generator` channels in the iKinematics IP. It holds a shadow bank written by the AXI register side, applies all channels atomically on a commit strobe, and sequences channel enables one at a time to limit servo inrush current. Its outputs drive the `PWM_IN`, `EN` and `COMPLEMENT` inputs of the generator array directly.

---
 rtl/servo_bank_scheduler.sv | 149 ++++++++++++++
 tb/tb_servo_bank_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_bank_scheduler.sv
// Shadow/active position banks for a servo PWM generator array, with atomic commit and
// a staggered channel-enable sequencer that limits inrush current.
module servo_bank_scheduler #(
   parameter int unsigned C_NUM_SERVOS                    = 18,
   parameter int unsigned C_PWM_SIZE                      = 8,
   parameter int unsigned C_PWM_MAX_IN                    = 200,
   parameter int unsigned C_PWM_DEFAULT                   = 100,
   parameter int unsigned C_STAGGER_CYCLES                = 1000,
   parameter logic [C_NUM_SERVOS-1:0] C_COMPLEMENT_MASK   = '0,
   // One spare code above N-1 is kept even for power-of-two N so bad indices stay visible.
   localparam int unsigned AW                             = $clog2(C_NUM_SERVOS + 1)
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic                               WR_VALID,
   output logic                               WR_READY,
   input  logic [AW-1:0]                      WR_ADDR,
   input  logic [C_PWM_SIZE-1:0]              WR_DATA,
   input  logic                               COMMIT,
   input  logic                               START,
   input  logic                               STOP,
   input  logic                               ERR_CLR,
   output logic [C_NUM_SERVOS*C_PWM_SIZE-1:0] PWM_IN_BUS,
   output logic [C_NUM_SERVOS-1:0]            EN_BUS,
   output logic [C_NUM_SERVOS-1:0]            COMPLEMENT_BUS,
   output logic                               BUSY,
   output logic                               ALL_ENABLED,
   output logic                               ADDR_ERR,
   output logic                               CLAMP_ERR
);

   localparam int unsigned N  = C_NUM_SERVOS;
   localparam int unsigned W  = C_PWM_SIZE;
   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = (C_STAGGER_CYCLES > 1) ? $clog2(C_STAGGER_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StStagger, StRun} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [N-1:0]     en_q, en_d;
   logic             busy_q, all_q, ready_q, addr_err_q, clamp_err_q;
   logic [W-1:0]     shadow_q [N];
   logic [N*W-1:0]   active_q;

   logic             wr_fire, addr_ok, over;
   logic [IW-1:0]    wr_idx;
   logic [W-1:0]     wr_val;

   assign wr_fire = WR_VALID & ready_q;
   assign addr_ok = (WR_ADDR < AW'(N));
   assign wr_idx  = WR_ADDR[IW-1:0];
   assign over    = (WR_DATA > W'(C_PWM_MAX_IN));
   assign wr_val  = over ? W'(C_PWM_MAX_IN) : WR_DATA;

   always_ff @(posedge CLK) begin
      if (RST) begin
         ready_q     <= 1'b0;
         addr_err_q  <= 1'b0;
         clamp_err_q <= 1'b0;
         for (int k = 0; k < int'(N); k++) begin
            shadow_q[k]           <= W'(C_PWM_DEFAULT);
            active_q[k*W +: W]    <= W'(C_PWM_DEFAULT);
         end
      end else begin
         ready_q     <= 1'b1;
         addr_err_q  <= (addr_err_q & ~ERR_CLR) | (wr_fire & ~addr_ok);
         clamp_err_q <= (clamp_err_q & ~ERR_CLR) | (wr_fire & addr_ok & over);
         // Commit samples the old shadow, so a same-cycle write is left for the next commit.
         if (COMMIT) begin
            for (int k = 0; k < int'(N); k++) active_q[k*W +: W] <= shadow_q[k];
         end
         if (wr_fire && addr_ok) shadow_q[wr_idx] <= wr_val;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         en_q    <= '0;
         busy_q  <= 1'b0;
         all_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
         busy_q  <= (state_d == StStagger);
         all_q   <= (state_d == StRun);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      en_d    = en_q;
      if (STOP) begin
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
         en_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               en_d = '0;
               if (START) begin
                  state_d = StStagger;
                  en_d    = {{(N-1){1'b0}}, 1'b1};
                  idx_d   = IW'(1);
                  cnt_d   = '0;
               end
            end
            StStagger: begin
               if (cnt_q == CW'(C_STAGGER_CYCLES - 1)) begin
                  cnt_d        = '0;
                  en_d[idx_q]  = 1'b1;
                  if (idx_q == IW'(N - 1)) begin
                     state_d = StRun;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            StRun: en_d = '1;
            default: begin
               state_d = StIdle;
               en_d    = '0;
            end
         endcase
      end
   end

   assign WR_READY       = ready_q;
   assign PWM_IN_BUS     = active_q;
   assign EN_BUS         = en_q;
   assign COMPLEMENT_BUS = C_COMPLEMENT_MASK;
   assign BUSY           = busy_q;
   assign ALL_ENABLED    = all_q;
   assign ADDR_ERR       = addr_err_q;
   assign CLAMP_ERR      = clamp_err_q;

endmodule

// File: tb/tb_servo_bank_scheduler.sv
// Directed bench for servo_bank_scheduler: table-driven bank/error vectors plus
// hand-written enable-sequencing, stop and mid-sequence reset scenarios.
module tb_servo_bank_scheduler;

   localparam int N = 4;
   localparam int W = 8;
   localparam int S = 10;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           WR_VALID = 1'b0;
   logic           WR_READY;
   logic [2:0]     WR_ADDR = '0;
   logic [W-1:0]   WR_DATA = '0;
   logic           COMMIT = 1'b0;
   logic           START = 1'b0;
   logic           STOP = 1'b0;
   logic           ERR_CLR = 1'b0;
   logic [N*W-1:0] PWM_IN_BUS;
   logic [N-1:0]   EN_BUS;
   logic [N-1:0]   COMPLEMENT_BUS;
   logic           BUSY, ALL_ENABLED, ADDR_ERR, CLAMP_ERR;

   servo_bank_scheduler #(
      .C_NUM_SERVOS     (N),
      .C_PWM_SIZE       (W),
      .C_PWM_MAX_IN     (200),
      .C_PWM_DEFAULT    (100),
      .C_STAGGER_CYCLES (S),
      .C_COMPLEMENT_MASK(4'b0000)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .WR_VALID      (WR_VALID),
      .WR_READY      (WR_READY),
      .WR_ADDR       (WR_ADDR),
      .WR_DATA       (WR_DATA),
      .COMMIT        (COMMIT),
      .START         (START),
      .STOP          (STOP),
      .ERR_CLR       (ERR_CLR),
      .PWM_IN_BUS    (PWM_IN_BUS),
      .EN_BUS        (EN_BUS),
      .COMPLEMENT_BUS(COMPLEMENT_BUS),
      .BUSY          (BUSY),
      .ALL_ENABLED   (ALL_ENABLED),
      .ADDR_ERR      (ADDR_ERR),
      .CLAMP_ERR     (CLAMP_ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wv;
      logic [2:0]  addr;
      logic [7:0]  data;
      logic        commit;
      logic        clr;
      logic [31:0] pwm;
      logic        aerr;
      logic        cerr;
   } vec_t;

   vec_t vt[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
      return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
   endfunction

   function automatic vec_t mk(input logic wv, input int addr, input int data, input logic commit,
                               input logic clr, input logic [31:0] pwm, input logic aerr,
                               input logic cerr);
      vec_t v;
      v.wv = wv; v.addr = addr[2:0]; v.data = data[7:0]; v.commit = commit; v.clr = clr;
      v.pwm = pwm; v.aerr = aerr; v.cerr = cerr;
      return v;
   endfunction

   // Expected enable pattern k edges after the START edge.
   function automatic logic [3:0] en_exp(input int k);
      int n;
      n = 1 + k / S;
      if (n > N) n = N;
      return 4'((1 << n) - 1);
   endfunction

   task automatic do_write(input int addr, input int data);
      WR_VALID = 1'b1; WR_ADDR = addr[2:0]; WR_DATA = data[7:0];
      step();
      WR_VALID = 1'b0;
   endtask

   initial begin
      vt[0]  = mk(1, 1, 150, 0, 0, pk(100, 100, 100, 100), 0, 0);
      vt[1]  = mk(1, 3,  20, 0, 0, pk(100, 100, 100, 100), 0, 0);
      vt[2]  = mk(1, 2,  50, 1, 0, pk(100, 150, 100,  20), 0, 0);
      vt[3]  = mk(0, 0,   0, 0, 0, pk(100, 150, 100,  20), 0, 0);
      vt[4]  = mk(0, 0,   0, 1, 0, pk(100, 150,  50,  20), 0, 0);
      vt[5]  = mk(1, 0, 250, 0, 0, pk(100, 150,  50,  20), 0, 1);
      vt[6]  = mk(0, 0,   0, 1, 0, pk(200, 150,  50,  20), 0, 1);
      vt[7]  = mk(1, 5,  77, 0, 0, pk(200, 150,  50,  20), 1, 1);
      vt[8]  = mk(0, 0,   0, 1, 0, pk(200, 150,  50,  20), 1, 1);
      vt[9]  = mk(0, 0,   0, 0, 1, pk(200, 150,  50,  20), 0, 0);
      vt[10] = mk(1, 2, 230, 0, 1, pk(200, 150,  50,  20), 0, 1);
      vt[11] = mk(1, 4,  10, 0, 1, pk(200, 150,  50,  20), 1, 0);
      vt[12] = mk(0, 0,   0, 0, 1, pk(200, 150,  50,  20), 0, 0);
      vt[13] = mk(0, 0,   0, 1, 0, pk(200, 150, 200,  20), 0, 0);

      // Reset state and WR_READY release timing
      repeat (3) step();
      check("rst_pwm", PWM_IN_BUS, pk(100, 100, 100, 100));
      check("rst_en", EN_BUS, 0);
      check("rst_busy", BUSY, 0);
      check("rst_all", ALL_ENABLED, 0);
      check("rst_aerr", ADDR_ERR, 0);
      check("rst_cerr", CLAMP_ERR, 0);
      RST = 1'b0;
      check("ready_first", WR_READY, 0);
      step();
      check("ready_second", WR_READY, 1);
      check("complement", COMPLEMENT_BUS, 0);

      for (int i = 0; i < 14; i++) begin
         WR_VALID = vt[i].wv; WR_ADDR = vt[i].addr; WR_DATA = vt[i].data;
         COMMIT = vt[i].commit; ERR_CLR = vt[i].clr;
         step();
         WR_VALID = 1'b0; COMMIT = 1'b0; ERR_CLR = 1'b0;
         check($sformatf("vec%0d_pwm", i), PWM_IN_BUS, vt[i].pwm);
         check($sformatf("vec%0d_aerr", i), ADDR_ERR, vt[i].aerr);
         check($sformatf("vec%0d_cerr", i), CLAMP_ERR, vt[i].cerr);
         check($sformatf("vec%0d_en", i), EN_BUS, 0);
      end

      // Full staggered enable sequence
      START = 1'b1;
      step();
      START = 1'b0;
      check("seq_k0_en", EN_BUS, 4'b0001);
      check("seq_k0_busy", BUSY, 1);
      check("seq_k0_all", ALL_ENABLED, 0);
      for (int k = 1; k <= 3 * S + 2; k++) begin
         step();
         check($sformatf("seq_k%0d_en", k), EN_BUS, en_exp(k));
         check($sformatf("seq_k%0d_busy", k), BUSY, (k < 3 * S) ? 1 : 0);
         check($sformatf("seq_k%0d_all", k), ALL_ENABLED, (k >= 3 * S) ? 1 : 0);
      end
      START = 1'b1;
      step();
      START = 1'b0;
      check("run_start_ignored_en", EN_BUS, 4'b1111);
      check("run_start_ignored_all", ALL_ENABLED, 1);
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      check("run_stop_en", EN_BUS, 0);
      check("run_stop_all", ALL_ENABLED, 0);
      check("run_stop_busy", BUSY, 0);

      // STOP mid-sequence, then restart from channel 0
      START = 1'b1;
      step();
      START = 1'b0;
      repeat (14) step();
      check("mid_k14_en", EN_BUS, 4'b0011);
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      check("mid_stop_en", EN_BUS, 0);
      check("mid_stop_busy", BUSY, 0);
      START = 1'b1;
      step();
      START = 1'b0;
      check("restart_k0_en", EN_BUS, 4'b0001);
      repeat (9) step();
      check("restart_k9_en", EN_BUS, 4'b0001);
      step();
      check("restart_k10_en", EN_BUS, 4'b0011);
      STOP = 1'b1;
      step();
      STOP = 1'b0;

      // START and STOP together stay in IDLE
      START = 1'b1; STOP = 1'b1;
      step();
      START = 1'b0; STOP = 1'b0;
      check("startstop_en", EN_BUS, 0);
      check("startstop_busy", BUSY, 0);
      repeat (12) step();
      check("startstop_later_en", EN_BUS, 0);

      // Mid-sequence reset after a committed ch1=150 and a pending address error
      do_write(1, 150);
      COMMIT = 1'b1;
      step();
      COMMIT = 1'b0;
      check("pre_rst_pwm", PWM_IN_BUS, pk(200, 150, 200, 20));
      START = 1'b1;
      step();
      START = 1'b0;
      do_write(7, 1);
      repeat (23) step();
      check("pre_rst_en", EN_BUS, 4'b0111);
      check("pre_rst_aerr", ADDR_ERR, 1);
      RST = 1'b1;
      step();
      check("rst_mid_pwm", PWM_IN_BUS, pk(100, 100, 100, 100));
      check("rst_mid_en", EN_BUS, 0);
      check("rst_mid_busy", BUSY, 0);
      check("rst_mid_all", ALL_ENABLED, 0);
      check("rst_mid_aerr", ADDR_ERR, 0);
      check("rst_mid_ready", WR_READY, 0);
      RST = 1'b0;
      step();
      check("rst_mid_ready2", WR_READY, 1);
      COMMIT = 1'b1;
      step();
      COMMIT = 1'b0;
      check("rst_mid_shadow", PWM_IN_BUS, pk(100, 100, 100, 100));
      repeat (12) step();
      check("rst_mid_idle_en", EN_BUS, 0);
      check("rst_mid_idle_busy", BUSY, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
